gf180mcu_osu_sc_12t_tiehold_seq: RTL



---
 rtl/gf180mcu_osu_sc_12t_tiehold_seq.sv | 129 ++++++++++++
 1 files changed

// File: rtl/gf180mcu_osu_sc_12t_tiehold_seq.sv
// Power-up safe-default sequencer: outputs hold at tie-low, then release to 1 in a staggered thermometer order.
// Optional macro GF180MCU_OSU_SC_12T_TIEHOLD_SYNC_EN adds a 2-flop reset-release synchronizer on RN.
module gf180mcu_osu_sc_12t_tiehold_seq #(
  parameter int N_OUT       = 4,
  parameter int HOLD_CYCLES = 16,
  parameter int STAGGER     = 4,
  parameter int CNT_W       = 8
) (
  input  logic             CLK,
  input  logic             RN,
  input  logic             EN,
  input  logic             FORCE_LO,
  output logic [N_OUT-1:0] Y,
  output logic             BUSY,
  output logic             DONE,
  output logic [1:0]       DBG_STATE
);

  localparam int IDX_W = 6;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_HOLD    = 2'd1,
    S_RELEASE = 2'd2,
    S_FINISH  = 2'd3
  } state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   hold_cnt_q;
  logic [CNT_W-1:0]   stag_cnt_q;
  logic [IDX_W-1:0]   idx_q;
  logic [N_OUT-1:0]   y_q;
  logic               busy_q;
  logic               done_q;
  logic [N_OUT-1:0]   y_d;
  logic               rst_int_n;

`ifdef GF180MCU_OSU_SC_12T_TIEHOLD_SYNC_EN
  logic [1:0] rst_sync_q;

  // Asserts immediately with RN; releases two CLK edges after RN rises.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_int_n = rst_sync_q[1];
`else
  assign rst_int_n = RN;
`endif

  // Shifting a 1 in from the bottom keeps Y a thermometer code by construction.
  assign y_d = (y_q << 1) | N_OUT'(1);

  always_ff @(posedge CLK or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q    <= S_IDLE;
      hold_cnt_q <= '0;
      stag_cnt_q <= '0;
      idx_q      <= '0;
      y_q        <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else if (FORCE_LO) begin
      state_q    <= S_IDLE;
      hold_cnt_q <= '0;
      stag_cnt_q <= '0;
      idx_q      <= '0;
      y_q        <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (EN) begin
            state_q    <= S_HOLD;
            hold_cnt_q <= CNT_W'(HOLD_CYCLES - 1);
            busy_q     <= 1'b1;
          end
        end
        S_HOLD: begin
          if (hold_cnt_q == '0) begin
            y_q <= y_d;
            if (N_OUT == 1) begin
              state_q <= S_FINISH;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q    <= S_RELEASE;
              stag_cnt_q <= CNT_W'(STAGGER - 1);
              idx_q      <= IDX_W'(1);
            end
          end else begin
            hold_cnt_q <= hold_cnt_q - 1'b1;
          end
        end
        S_RELEASE: begin
          if (stag_cnt_q == '0) begin
            y_q        <= y_d;
            idx_q      <= idx_q + 1'b1;
            stag_cnt_q <= CNT_W'(STAGGER - 1);
            if (idx_q == IDX_W'(N_OUT - 1)) begin
              state_q <= S_FINISH;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end else begin
            stag_cnt_q <= stag_cnt_q - 1'b1;
          end
        end
        S_FINISH: begin
          state_q <= S_FINISH;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign Y         = y_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign DBG_STATE = state_q;

endmodule
